// File: rtl/rsa_uart_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_uart_ctrl
// Avalon-MM master that drives an RS232 UART and sequences an RSA256 decryption
// core. It polls the UART and collects the modulus n, the private key d and the
// ciphertext a, 32 bytes each and MSB-first. It then pulses the core start,
// waits for the core to finish and returns 31 plaintext bytes, MSB-first, to
// the UART. After reset, n and d are loaded once. Later ciphertexts reuse them.
//
// Ports
//   i_clk, i_rst        clock; asynchronous active-high reset
//   avm_*               Avalon-MM master (address/read/write/writedata/
//                       readdata/waitrequest) towards the UART IP
//   o_core_start        one-cycle start pulse to the core
//   o_core_a/d/n        operands to the core (these are the shift registers)
//   i_core_result       core result (o_a_pow_d[255:0])
//   i_core_finished     core done flag
//   i_key_reload        only with RSA_KEY_RELOAD_EN defined: requests a new
//                       n/d before the next ciphertext
//
// Optional feature macro: RSA_KEY_RELOAD_EN
// -----------------------------------------------------------------------------
module rsa_uart_ctrl #(
   parameter int KEY_BYTES   = 32,
   parameter int OUT_BYTES   = 31,
   parameter int RX_BASE     = 0,
   parameter int TX_BASE     = 4,
   parameter int STATUS_BASE = 8,
   parameter int RX_OK_BIT   = 7,
   parameter int TX_OK_BIT   = 6
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   output logic [4:0]             avm_address,
   output logic                   avm_read,
   input  logic [31:0]            avm_readdata,
   output logic                   avm_write,
   output logic [31:0]            avm_writedata,
   input  logic                   avm_waitrequest,
   output logic                   o_core_start,
   output logic [8*KEY_BYTES-1:0] o_core_a,
   output logic [8*KEY_BYTES-1:0] o_core_d,
   output logic [8*KEY_BYTES-1:0] o_core_n,
   input  logic [8*KEY_BYTES-1:0] i_core_result,
   input  logic                   i_core_finished
`ifdef RSA_KEY_RELOAD_EN
   ,
   input  logic                   i_key_reload
`endif
);

   localparam int OP_W  = 8 * KEY_BYTES;
   localparam int CNT_W = $clog2(KEY_BYTES);

   localparam logic [4:0]       ADDR_RX     = 5'(RX_BASE);
   localparam logic [4:0]       ADDR_TX     = 5'(TX_BASE);
   localparam logic [4:0]       ADDR_STATUS = 5'(STATUS_BASE);
   localparam logic [CNT_W-1:0] LAST_RX     = CNT_W'(KEY_BYTES - 1);
   localparam logic [CNT_W-1:0] LAST_TX     = CNT_W'(OUT_BYTES - 1);

   typedef enum logic [2:0] {
      S_QUERY_RX,
      S_READ,
      S_START,
      S_WAIT_CALC,
      S_QUERY_TX,
      S_WRITE
   } state_t;

   typedef enum logic [1:0] {
      P_N,
      P_D,
      P_A
   } phase_t;

   state_t            state_reg, state_next;
   phase_t            phase_reg, phase_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [OP_W-1:0]   n_reg, n_next;
   logic [OP_W-1:0]   d_reg, d_next;
   logic [OP_W-1:0]   a_reg, a_next;
   logic [OP_W-1:0]   result_reg, result_next;

   // The plaintext byte for each TX index. Index 0 is result[247:240]. The
   // result's top byte is never sent. Indices past OUT_BYTES are not reachable.
   logic [7:0] tx_bytes [0:(1<<CNT_W)-1];

   genvar gi;
   generate
      for (gi = 0; gi < (1 << CNT_W); gi++) begin : g_tx_byte
         if (gi < OUT_BYTES) begin : g_live
            assign tx_bytes[gi] = result_reg[OP_W-9-8*gi -: 8];
         end else begin : g_pad
            assign tx_bytes[gi] = 8'h00;
         end
      end
   endgenerate

   // Upper read-data bits and the dropped result byte have no function.
   logic unused_bits;
   assign unused_bits = ^{avm_readdata[31:8], result_reg[OP_W-1:OP_W-8]};

   assign o_core_n = n_reg;
   assign o_core_d = d_reg;
   assign o_core_a = a_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg  <= S_QUERY_RX;
         phase_reg  <= P_N;
         cnt_reg    <= '0;
         n_reg      <= '0;
         d_reg      <= '0;
         a_reg      <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         phase_reg  <= phase_next;
         cnt_reg    <= cnt_next;
         n_reg      <= n_next;
         d_reg      <= d_next;
         a_reg      <= a_next;
         result_reg <= result_next;
      end
   end

   // The bus request is decoded from the registered state alone. This holds it
   // constant across a stall. A transfer completes in the first cycle in which
   // waitrequest is low.
   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      cnt_next      = cnt_reg;
      n_next        = n_reg;
      d_next        = d_reg;
      a_next        = a_reg;
      result_next   = result_reg;
      avm_address   = ADDR_STATUS;
      avm_read      = 1'b0;
      avm_write     = 1'b0;
      avm_writedata = '0;
      o_core_start  = 1'b0;

      case (state_reg)
         S_QUERY_RX: begin
            avm_read    = 1'b1;
            avm_address = ADDR_STATUS;
`ifdef RSA_KEY_RELOAD_EN
            // A reload is taken only between ciphertexts. This way no byte
            // that has already been collected is lost.
            if (i_key_reload && phase_reg == P_A && cnt_reg == '0)
               phase_next = P_N;
`endif
            if (!avm_waitrequest && avm_readdata[RX_OK_BIT])
               state_next = S_READ;
         end

         S_READ: begin
            avm_read    = 1'b1;
            avm_address = ADDR_RX;
            if (!avm_waitrequest) begin
               case (phase_reg)
                  P_N:     n_next = {n_reg[OP_W-9:0], avm_readdata[7:0]};
                  P_D:     d_next = {d_reg[OP_W-9:0], avm_readdata[7:0]};
                  default: a_next = {a_reg[OP_W-9:0], avm_readdata[7:0]};
               endcase
               if (cnt_reg == LAST_RX) begin
                  cnt_next = '0;
                  case (phase_reg)
                     P_N: begin
                        phase_next = P_D;
                        state_next = S_QUERY_RX;
                     end
                     P_D: begin
                        phase_next = P_A;
                        state_next = S_QUERY_RX;
                     end
                     default: state_next = S_START;
                  endcase
               end else begin
                  cnt_next   = cnt_reg + 1'b1;
                  state_next = S_QUERY_RX;
               end
            end
         end

         S_START: begin
            o_core_start = 1'b1;
            state_next   = S_WAIT_CALC;
         end

         // The done flag left over from the previous run is still high while
         // in S_START. It is sampled here only, after the core has cleared it.
         S_WAIT_CALC: begin
            if (i_core_finished) begin
               result_next = i_core_result;
               cnt_next    = '0;
               state_next  = S_QUERY_TX;
            end
         end

         S_QUERY_TX: begin
            avm_read    = 1'b1;
            avm_address = ADDR_STATUS;
            if (!avm_waitrequest && avm_readdata[TX_OK_BIT])
               state_next = S_WRITE;
         end

         S_WRITE: begin
            avm_write     = 1'b1;
            avm_address   = ADDR_TX;
            avm_writedata = {24'h000000, tx_bytes[cnt_reg]};
            if (!avm_waitrequest) begin
               if (cnt_reg == LAST_TX) begin
                  cnt_next   = '0;
                  state_next = S_QUERY_RX;
               end else begin
                  cnt_next   = cnt_reg + 1'b1;
                  state_next = S_QUERY_TX;
               end
            end
         end

         default: state_next = S_QUERY_RX;
      endcase
   end

endmodule

// File: tb/tb_rsa_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rsa_uart_ctrl
// Testbench for rsa_uart_ctrl. It contains three parts:
//   - a UART slave model with random 0-5 cycle stalls, an RX byte queue and a
//     TX capture queue,
//   - a core model that clears its done flag after start and raises it again
//     300 cycles later,
//   - a table of ciphertext transactions, with hand-written sequences for
//     reset in the middle of an operation and for key reload.
// -----------------------------------------------------------------------------
module tb_rsa_uart_ctrl;

   localparam int KB       = 32;
   localparam int OB       = 31;
   localparam int CORE_LAT = 300;
   localparam int BUDGET   = 20000;

   localparam logic [255:0] N1 = 256'hCA3586E7_EA485F3B_0A222A4C_79F7DD12_E85388EC_CDEE4035_940D774C_029CF831;
   localparam logic [255:0] D1 = 256'hB6ACE0B1_47201698_39B15FD1_3326CF1A_1829BEAF_C37BB937_BEC8802F_BCF46BD9;
   localparam logic [255:0] N2 = 256'h8F14E45F_CEEA167A_5A36DEDD_4BEA2543_00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [255:0] D2 = 256'h0A0B0C0D_0E0F1011_12131415_16171819_1A1B1C1D_1E1F2021_22232425_26272829;
   localparam logic [255:0] A1 = 256'h1EE5F3D2_7A0B0C9D_3F224E61_5C8A9B07_D4E3F201_6B7A8C9D_0E1F2A3B_4C5D6E7F;
   localparam logic [255:0] A2 = 256'h99887766_55443322_11FFEEDD_CCBBAA00_13579BDF_2468ACE0_F0E1D2C3_B4A59687;
   localparam logic [255:0] A3 = 256'h55555555_AAAAAAAA_33333333_CCCCCCCC_0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
   localparam logic [255:0] R1 = 256'h00AB1234_56789ABC_DEF01357_9BDF0246_8ACE1122_33445566_778899AA_BBCCDD01;
   localparam logic [255:0] R2 = 256'hFF010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;

   logic         i_clk;
   logic         i_rst;
   logic [4:0]   avm_address;
   logic         avm_read;
   logic [31:0]  avm_readdata;
   logic         avm_write;
   logic [31:0]  avm_writedata;
   logic         avm_waitrequest;
   logic         o_core_start;
   logic [255:0] o_core_a, o_core_d, o_core_n;
   logic [255:0] i_core_result;
   logic         i_core_finished;
   logic         key_reload;

   rsa_uart_ctrl dut (
`ifdef RSA_KEY_RELOAD_EN
      .i_key_reload    (key_reload),
`endif
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .o_core_start    (o_core_start),
      .o_core_a        (o_core_a),
      .o_core_d        (o_core_d),
      .o_core_n        (o_core_n),
      .i_core_result   (i_core_result),
      .i_core_finished (i_core_finished)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic         load_key;
      logic [255:0] n;
      logic [255:0] d;
      logic [255:0] a;
      logic [255:0] res;
      logic [255:0] exp_n;
      logic [255:0] exp_d;
      int           tx_stall;
   } vec_t;

   int           n_cmp  = 0;
   int           n_fail = 0;
   logic [7:0]   rx_q[$];
   logic [7:0]   tx_q[$];
   int           tx_block     = 0;
   int           tx_block_arm = 0;
   bit           force_stall  = 0;
   logic [255:0] next_result  = '0;
   int           start_count  = 0;
   logic [255:0] cap_n, cap_d, cap_a;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic push_op(input logic [255:0] v);
      for (int i = KB - 1; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_addr"},  avm_address, 5'd8);
      check({tag, "_read"},  avm_read, 1'b1);
      check({tag, "_write"}, avm_write, 1'b0);
      check({tag, "_wdata"}, avm_writedata, 32'h0);
      check({tag, "_start"}, o_core_start, 1'b0);
      check({tag, "_n"},     o_core_n, 256'h0);
      check({tag, "_d"},     o_core_d, 256'h0);
      check({tag, "_a"},     o_core_a, 256'h0);
   endtask

   task automatic wait_start(input int s0, input string tag);
      int t = 0;
      while (start_count == s0 && t < BUDGET) begin
         @(posedge i_clk);
         t++;
      end
      check({tag, "_start_seen"}, start_count - s0, 1);
   endtask

   task automatic wait_tx_done(input string tag);
      int t = 0;
      while (tx_q.size() < OB && t < BUDGET) begin
         @(posedge i_clk);
         t++;
      end
      repeat (40) @(posedge i_clk);
      check({tag, "_tx_count"}, tx_q.size(), OB);
   endtask

   // Sends one ciphertext, with a key first if the record asks for it. Then
   // checks the captured operands, the start count and the returned bytes.
   task automatic run_vec(input vec_t v, input string tag);
      int s0;
      logic [255:0] sh;
      s0 = start_count;
      tx_q.delete();
      next_result  = v.res;
      tx_block_arm = v.tx_stall;
      if (v.load_key) begin
         push_op(v.n);
         push_op(v.d);
      end
      push_op(v.a);
      wait_tx_done(tag);
      check({tag, "_start_pulses"}, start_count - s0, 1);
      check({tag, "_core_n"}, cap_n, v.exp_n);
      check({tag, "_core_d"}, cap_d, v.exp_d);
      check({tag, "_core_a"}, cap_a, v.a);
      check({tag, "_n_kept"}, o_core_n, v.exp_n);
      for (int k = 0; k < OB && k < tx_q.size(); k++) begin
         sh = v.res >> (8 * (OB - 1 - k));
         check($sformatf("%s_tx%0d", tag, k), tx_q[k], sh[7:0]);
      end
      $display("txn %s: key=%0d a=%h tx_bytes=%0d starts=%0d", tag, v.load_key, v.a,
               tx_q.size(), start_count - s0);
   endtask

   // UART slave model: decisions are taken on the falling edge, and the DUT
   // samples them on the next rising edge.
   initial begin
      int         stall_left;
      bit         prev_stall;
      logic [38:0] prev_req;
      stall_left      = -1;
      prev_stall      = 0;
      prev_req        = '0;
      avm_waitrequest = 1'b0;
      avm_readdata    = '0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            avm_waitrequest = 1'b0;
            prev_stall      = 0;
            stall_left      = -1;
         end else begin
            check("rw_exclusive", avm_read & avm_write, 1'b0);
            if (prev_stall)
               check("req_held", {avm_read, avm_write, avm_address, avm_writedata}, prev_req);
            if (avm_read || avm_write) begin
               if (stall_left < 0) stall_left = $urandom_range(0, 5);
               if ((force_stall && avm_read && avm_address == 5'd0) || stall_left > 0) begin
                  avm_waitrequest = 1'b1;
                  avm_readdata    = $urandom;
                  if (stall_left > 0) stall_left--;
                  prev_stall = 1;
                  prev_req   = {avm_read, avm_write, avm_address, avm_writedata};
               end else begin
                  avm_waitrequest = 1'b0;
                  prev_stall      = 0;
                  stall_left      = -1;
                  avm_readdata    = $urandom;
                  if (avm_write) begin
                     check("tx_addr", avm_address, 5'd4);
                     check("tx_upper_zero", avm_writedata[31:8], 24'h0);
                     check("tx_gated", tx_block, 0);
                     tx_q.push_back(avm_writedata[7:0]);
                  end else if (avm_address == 5'd0) begin
                     check("rx_nonempty", rx_q.size() != 0, 1'b1);
                     if (rx_q.size() != 0) avm_readdata[7:0] = rx_q.pop_front();
                  end else begin
                     check("rd_addr", avm_address, 5'd8);
                     avm_readdata[7] = (rx_q.size() != 0);
                     avm_readdata[6] = (tx_block == 0);
                     if (tx_block > 0) tx_block--;
                  end
               end
            end else begin
               avm_waitrequest = 1'b0;
               prev_stall      = 0;
               avm_readdata    = $urandom;
            end
         end
      end
   end

   // Core model. The done flag stays high until one edge after the start
   // pulse has been sampled.
   initial begin
      int countdown;
      bit clear_pending;
      countdown       = -1;
      clear_pending   = 0;
      i_core_finished = 1'b0;
      i_core_result   = '0;
      forever begin
         @(negedge i_clk);
         if (clear_pending) begin
            i_core_finished = 1'b0;
            clear_pending   = 0;
         end
         if (o_core_start) begin
            start_count++;
            cap_n         = o_core_n;
            cap_d         = o_core_d;
            cap_a         = o_core_a;
            clear_pending = 1;
            countdown     = CORE_LAT;
         end else if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               i_core_finished = 1'b1;
               i_core_result   = next_result;
               tx_block        = tx_block_arm;
               tx_block_arm    = 0;
               countdown       = -1;
            end
         end
      end
   end

   // Resets while the core is running. The finish of the aborted run arrives
   // while the DUT idles and must be ignored.
   task automatic seq_reset_wait_calc();
      int s0;
      s0 = start_count;
      tx_q.delete();
      next_result = R2;
      push_op(A3);
      wait_start(s0, "rwc");
      repeat (20) @(posedge i_clk);
      #2 i_rst = 1'b1;
      #1 check_reset("rst_wait_calc");
      repeat (3) @(posedge i_clk);
      @(negedge i_clk) i_rst = 1'b0;
      repeat (CORE_LAT + 100) @(posedge i_clk);
      check("rwc_no_tx", tx_q.size(), 0);
      check("rwc_no_restart", start_count - s0, 1);
      $display("txn reset_in_wait_calc: tx_bytes=%0d", tx_q.size());
   endtask

   // Resets while an RX data read is held in a stall.
   task automatic seq_reset_stalled_rx();
      int t = 0;
      force_stall = 1;
      push_op(A2);
      while (!(avm_read && avm_address == 5'd0) && t < BUDGET) begin
         @(posedge i_clk);
         t++;
      end
      check("rsr_rx_read_seen", avm_read && avm_address == 5'd0, 1'b1);
      repeat (3) @(posedge i_clk);
      #2 i_rst = 1'b1;
      #1 check_reset("rst_stalled_rx");
      rx_q.delete();
      force_stall = 0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk) i_rst = 1'b0;
      $display("txn reset_in_stalled_rx: done");
   endtask

   vec_t vecs [4];

   initial begin
      vecs[0] = '{1'b1, N1, D1, A1, R1, N1, D1, 0};
      vecs[1] = '{1'b0, 256'h0, 256'h0, A2, R2, N1, D1, 50};
      vecs[2] = '{1'b1, N2, D2, A1, R1, N2, D2, 0};
      vecs[3] = '{1'b1, N1, D1, A2, R2, N1, D1, 0};

      key_reload = 1'b0;
      i_rst      = 1'b1;
      repeat (3) @(posedge i_clk);
      #1 check_reset("rst_init");
      @(negedge i_clk) i_rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         if (i == 2) seq_reset_wait_calc();
         if (i == 3) seq_reset_stalled_rx();
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

`ifdef RSA_KEY_RELOAD_EN
      begin
         vec_t vr;
         int   s0;
         int   t;
         repeat (5) @(posedge i_clk);
         @(negedge i_clk) key_reload = 1'b1;
         @(negedge i_clk) key_reload = 1'b0;
         vr = '{1'b1, N2, D2, A3, R1, N2, D2, 0};
         run_vec(vr, "reload");

         // A pulse during a stalled RX read must leave the phase alone.
         force_stall = 1;
         tx_q.delete();
         s0 = start_count;
         next_result = R2;
         push_op(A1);
         t = 0;
         while (!(avm_read && avm_address == 5'd0) && t < BUDGET) begin
            @(posedge i_clk);
            t++;
         end
         @(negedge i_clk) key_reload = 1'b1;
         @(negedge i_clk) key_reload = 1'b0;
         force_stall = 0;
         wait_start(s0, "reload_ign");
         check("reload_ign_core_n", cap_n, N2);
         check("reload_ign_core_a", cap_a, A1);
         wait_tx_done("reload_ign");
         $display("txn reload_pulse_in_read: starts=%0d", start_count - s0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rsa_uart_ctrl.md
Name: rsa_uart_ctrl

Overview:
- Avalon-MM master controller that sequences the RSA256 decryption core.
- Polls the RS232 UART and collects the 256-bit modulus n, private key d and ciphertext a, byte by byte.
- Fires the core with a start pulse, waits for it to finish, then streams the plaintext back to the UART.
- Sits between the UART IP and the core; the core's i_a/i_d/i_n/i_start are driven only by this block.

Parameters:
- KEY_BYTES, 32, bytes per 256-bit operand.
- OUT_BYTES, 31, plaintext bytes returned; the top byte of the result is dropped.
- RX_BASE, 0, UART RX data register address.
- TX_BASE, 4, UART TX data register address.
- STATUS_BASE, 8, UART status register address.
- RX_OK_BIT, 7, status bit meaning RX data ready.
- TX_OK_BIT, 6, status bit meaning TX ready.

Ports:
- i_clk  in  1  clock; the single clock for the block.
- i_rst  in  1  asynchronous, active-high reset.
- avm_address  out  5  Avalon address.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  32  Avalon read data; only [7:0] and status bits are used.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  Avalon write data; [31:8] always 0.
- avm_waitrequest  in  1  Avalon stall.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_a  out  256  ciphertext to the core.
- o_core_d  out  256  private key to the core.
- o_core_n  out  256  modulus to the core.
- i_core_result  in  256  core result; bits [255:0] of the core's o_a_pow_d.
- i_core_finished  in  1  core done flag.

Behaviour:
- Reset values:
  - State S_QUERY_RX, phase P_N.
  - avm_address = STATUS_BASE, avm_read = 1, avm_write = 0, avm_writedata = 0.
  - o_core_start = 0; o_core_a, o_core_d, o_core_n = 0.
  - Byte counter = 0; result register = 0.
- Avalon handshake:
  - A request (read/write) and its address/data are held constant while avm_waitrequest = 1.
  - The transfer completes in the first cycle with avm_read|avm_write = 1 and avm_waitrequest = 0.
  - readdata is sampled in that cycle; the request deasserts or changes on the next edge.
  - Never more than one request at a time; avm_read and avm_write are never high together.
- States:
  - S_QUERY_RX: read STATUS_BASE. On completion, if readdata[RX_OK_BIT] = 1 → S_READ with address RX_BASE; else re-issue the status read.
  - S_READ: read RX_BASE. On completion, shift readdata[7:0] into the LSB of the shift register for the current phase (operand = {operand[247:0], byte}) and increment the byte counter.
    - Counter < 31 before the increment → S_QUERY_RX.
    - Counter = 31 → clear the counter, then advance phase P_N → P_D → P_A. P_N and P_D return to S_QUERY_RX. P_A → S_START.
  - S_START: o_core_start = 1 for exactly one cycle → S_WAIT_CALC. Phase stays P_A.
  - S_WAIT_CALC: no bus activity. On i_core_finished = 1, latch i_core_result → S_QUERY_TX with counter = 0.
  - S_QUERY_TX: read STATUS_BASE. On completion, if readdata[TX_OK_BIT] = 1 → S_WRITE; else re-issue the read.
  - S_WRITE: write TX_BASE with writedata[7:0] = result[247-8*k -: 8] for k = counter (MSB-first, bytes 30 down to 0).
    - On completion with k < OUT_BYTES-1 → increment k, go to S_QUERY_TX.
    - On completion with k = OUT_BYTES-1 → clear k, go to S_QUERY_RX in phase P_A.
- Key retention: n and d are kept; subsequent ciphertexts reuse them without reloading.
- o_core_a/d/n are the shift registers themselves. The core must only be started from S_START; operand changes while the core runs occur only after it finishes.
- Simultaneous/boundary cases:
  - i_core_finished outside S_WAIT_CALC is ignored.
  - A level-high finished from the previous run is not accepted in the S_START cycle; it is accepted only in S_WAIT_CALC, which is entered after the core clears its flag on start.
  - Status bits are checked only in the completion cycle.
  - Stalls of any length are tolerated.
- Reset mid-operation (any state, including mid-transfer): all registers return to reset values and the next byte received is treated as n[255:248]. A pending Avalon transfer is abandoned.

Optional Feature:
- Macro: RSA_KEY_RELOAD_EN.
- Defined: adds input port i_key_reload (1 bit).
  - A 1 sampled in S_QUERY_RX while in phase P_A with byte counter = 0 sets phase = P_N, so the next 64 bytes reload n and d.
  - Sampled in any other state, i_key_reload is ignored; pending bytes are never discarded.
- Undefined: port absent; the key is loaded only once after reset.

Test Plan:
- Reset, then feed n = 0xCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831, d = 0x..., then one ciphertext (64+32 bytes, random waitrequest stalls of 0-5 cycles) → exactly one o_core_start pulse, and o_core_n/d/a equal the fed values MSB-first.
- Core model returns result 0x00AB…01 after 300 cycles → 31 TX writes with writedata[7:0] = 0xAB first and 0x01 last; writedata[31:8] = 0.
- TX_OK held 0 for 50 status reads → no write issued until TX_OK = 1; no byte lost or duplicated.
- Second ciphertext without a key → core started with the previous n/d; o_core_n unchanged.
- Assert i_rst in S_WAIT_CALC and during a stalled RX read → outputs at reset values immediately; the next 32 bytes land in o_core_n.
- RSA_KEY_RELOAD_EN: pulse i_key_reload after the first decryption, feed new n/d/a → the core uses the new key; a pulse during S_READ has no effect.
